// File: rtl/poly1305_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poly1305_pkg
// Description : Shared types and constants for the Poly1305 finalisation
//               stage: FSM state encoding, fold multiplier, ADD5 seed and
//               limb counts.
// Revision    : 1.0 - initial release
// ============================================================================
package poly1305_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FOLD  = 3'd1,
        ST_CARRY = 3'd2,
        ST_ADD5  = 3'd3,
        ST_ADDS  = 3'd4
    } state_t;

    // 2^130 == 5 (mod p): bits at and above 2^130 fold back multiplied by 5.
    localparam int unsigned P_FOLD_MUL = 5;
    // x*5 is built as (x << FOLD_SHIFT) + x.
    localparam int unsigned FOLD_SHIFT = $clog2(P_FOLD_MUL - 1);

    // Seed for the h + 5 trial pass.
    localparam logic [33:0] ADD5_INIT = 34'd5;

    localparam logic [2:0] H_LIMBS   = 3'd5;
    localparam logic [2:0] TAG_LIMBS = 3'd4;

endpackage
`default_nettype wire

// File: rtl/poly1305_limb_add.sv
`default_nettype none
// ============================================================================
// Module      : poly1305_limb_add
// Description : Combinational 32-bit limb adder with a wide carry-in.
//               result = (limb + addend + carry_in) mod 2^32,
//               carry_out = (limb + addend + carry_in) >> 32.
// Revision    : 1.0 - initial release
// ============================================================================
module poly1305_limb_add (
    input  logic [31:0] limb_i,
    input  logic [31:0] addend_i,
    input  logic [33:0] carry_i,
    output logic [31:0] sum_o,
    output logic [33:0] carry_o
);

    // Worst case 2*(2^32-1) + (2^34-1) still fits in 35 bits.
    logic [34:0] w_sum;

    assign w_sum   = {3'b000, limb_i} + {3'b000, addend_i} + {1'b0, carry_i};
    assign sum_o   = w_sum[31:0];
    assign carry_o = {31'd0, w_sum[34:32]};

endmodule
`default_nettype wire

// File: rtl/poly1305_final.sv
`default_nettype none
// ============================================================================
// Module      : poly1305_final
// Description : Poly1305 finalisation. Fully reduces the accumulator h modulo
//               2^130-5 with two fold/carry passes, selects h or h-p via an
//               h+5 trial, adds s mod 2^128 and holds the tag. Limb-serial
//               around one shared adder.
// Revision    : 1.0 - initial release
// ============================================================================
module poly1305_final
    import poly1305_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    input  logic [31:0] h0,
    input  logic [31:0] h1,
    input  logic [31:0] h2,
    input  logic [31:0] h3,
    input  logic [31:0] h4,
    input  logic [31:0] s0,
    input  logic [31:0] s1,
    input  logic [31:0] s2,
    input  logic [31:0] s3,
    output logic [31:0] tag0,
    output logic [31:0] tag1,
    output logic [31:0] tag2,
    output logic [31:0] tag3
);

    state_t      state_q;
    logic        ready_q;
    logic        pass_q;
    logic        sel_q;
    logic [2:0]  idx_q;
    logic [33:0] carry_q;
    logic [31:0] h_q   [5];
    logic [31:0] g_q   [5];
    logic [31:0] s_q   [4];
    logic [31:0] tag_q [4];

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [33:0] w_cin;
    logic [31:0] w_sum;
    logic [33:0] w_cout;
    logic [31:0] w_fold_x;
    logic [33:0] w_fold;

    poly1305_limb_add u_add (
        .limb_i   (w_a),
        .addend_i (w_b),
        .carry_i  (w_cin),
        .sum_o    (w_sum),
        .carry_o  (w_cout)
    );

    // The fold product h4[31:2]*5 is at most 33 bits.
    assign w_fold = {w_cout[1:0], w_sum};

    // Steer the shared adder operands according to the current pass.
    always_comb begin
        w_fold_x = {2'b00, h_q[4][31:2]};
        w_a      = h_q[idx_q];
        w_b      = 32'd0;
        w_cin    = carry_q;
        case (state_q)
            ST_FOLD: begin
                w_a   = w_fold_x << FOLD_SHIFT;
                w_b   = w_fold_x;
                w_cin = 34'd0;
            end
            ST_ADDS: begin
                w_a = sel_q ? g_q[idx_q] : h_q[idx_q];
                w_b = s_q[idx_q[1:0]];
            end
            default: ;
        endcase
    end

    // Sequencer and limb registers; the limb counter clears on every state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            pass_q  <= 1'b0;
            sel_q   <= 1'b0;
            idx_q   <= 3'd0;
            carry_q <= 34'd0;
            for (int i = 0; i < 5; i++) begin
                h_q[i] <= 32'd0;
                g_q[i] <= 32'd0;
            end
            for (int i = 0; i < 4; i++) begin
                s_q[i]   <= 32'd0;
                tag_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        h_q[0]  <= h0;
                        h_q[1]  <= h1;
                        h_q[2]  <= h2;
                        h_q[3]  <= h3;
                        h_q[4]  <= h4;
                        s_q[0]  <= s0;
                        s_q[1]  <= s1;
                        s_q[2]  <= s2;
                        s_q[3]  <= s3;
                        pass_q  <= 1'b0;
                        idx_q   <= 3'd0;
                        ready_q <= 1'b0;
                        state_q <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    carry_q <= w_fold;
                    h_q[4]  <= {30'd0, h_q[4][1:0]};
                    idx_q   <= 3'd0;
                    state_q <= ST_CARRY;
                end
                ST_CARRY: begin
                    h_q[idx_q] <= w_sum;
                    carry_q    <= w_cout;
                    if (idx_q == H_LIMBS - 3'd1) begin
                        // Top carry is provably zero and is dropped here.
                        idx_q <= 3'd0;
                        if (pass_q) begin
                            carry_q <= ADD5_INIT;
                            state_q <= ST_ADD5;
                        end else begin
                            pass_q  <= 1'b1;
                            state_q <= ST_FOLD;
                        end
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                ST_ADD5: begin
                    g_q[idx_q] <= w_sum;
                    carry_q    <= w_cout;
                    if (idx_q == H_LIMBS - 3'd1) begin
                        // h+5 reaching 2^130 means h >= p, so use h-p (= g).
                        sel_q   <= (w_sum[31:2] != 30'd0);
                        carry_q <= 34'd0;
                        idx_q   <= 3'd0;
                        state_q <= ST_ADDS;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                ST_ADDS: begin
                    tag_q[idx_q[1:0]] <= w_sum;
                    carry_q           <= w_cout;
                    if (idx_q == TAG_LIMBS - 3'd1) begin
                        idx_q   <= 3'd0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                default: begin
                    idx_q   <= 3'd0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign tag0  = tag_q[0];
    assign tag1  = tag_q[1];
    assign tag2  = tag_q[2];
    assign tag3  = tag_q[3];

endmodule
`default_nettype wire

// File: tb/tb_poly1305_final.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly1305_final
// Description : Self-checking bench for poly1305_final. Expected tags come
//               from ((h mod p) + s) mod 2^128 computed with wide arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly1305_final;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ready;
    logic [31:0] h0, h1, h2, h3, h4;
    logic [31:0] s0, s1, s2, s3;
    logic [31:0] tag0, tag1, tag2, tag3;

    int          n_vec = 0;
    int          n_err = 0;
    logic [127:0] prev_tag;

    always #5 clk = ~clk;

    poly1305_final dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ready (ready),
        .h0    (h0),
        .h1    (h1),
        .h2    (h2),
        .h3    (h3),
        .h4    (h4),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .s3    (s3),
        .tag0  (tag0),
        .tag1  (tag1),
        .tag2  (tag2),
        .tag3  (tag3)
    );

    function automatic logic [127:0] ref_tag(input logic [159:0] h, input logic [127:0] s);
        logic [191:0] p;
        logic [191:0] acc;
        p   = (192'd1 << 130) - 192'd5;
        acc = {32'd0, h} % p;
        acc = acc + {64'd0, s};
        return acc[127:0];
    endfunction

    function automatic logic [159:0] rand160();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic apply(input logic [159:0] h, input logic [127:0] s);
        h0 = h[31:0];   h1 = h[63:32];  h2 = h[95:64];
        h3 = h[127:96]; h4 = h[159:128];
        s0 = s[31:0];   s1 = s[63:32];  s2 = s[95:64]; s3 = s[127:96];
    endtask

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One full run; bump>0 re-pulses start before edge number bump.
    task automatic run_vec(input string name, input logic [159:0] h,
                           input logic [127:0] s, input int bump);
        logic [127:0] exp;
        exp = ref_tag(h, s);
        apply(h, s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        apply(rand160(), rand128());
        check({name, ":ready_low"}, {127'd0, ready}, 128'd0);
        for (int c = 1; c <= 21; c++) begin
            if (c == bump) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 10) check({name, ":tag_hold"}, {tag3, tag2, tag1, tag0}, prev_tag);
            if (c == 20) check({name, ":ready_c20"}, {127'd0, ready}, 128'd0);
        end
        check({name, ":ready_c21"}, {127'd0, ready}, 128'd1);
        check({name, ":tag"}, {tag3, tag2, tag1, tag0}, exp);
        prev_tag = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [159:0] p160;
        p160 = (160'd1 << 130) - 160'd5;

        // Reset with start held high: start must not take effect.
        reset = 1'b1;
        start = 1'b1;
        apply(rand160(), rand128());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:ready", {127'd0, ready}, 128'd1);
        check("reset:tag0", {96'd0, tag0}, 128'd0);
        check("reset:tag1", {96'd0, tag1}, 128'd0);
        check("reset:tag2", {96'd0, tag2}, 128'd0);
        check("reset:tag3", {96'd0, tag3}, 128'd0);
        prev_tag = 128'd0;

        // Boundary vectors, issued back to back.
        run_vec("h_eq_p", p160, {4{32'h11111111}}, 0);
        check("h_eq_p:const", {tag3, tag2, tag1, tag0}, {4{32'h11111111}});
        run_vec("h_2p130m1", (160'd1 << 130) - 160'd1, 128'd0, 0);
        check("h_2p130m1:const", {tag3, tag2, tag1, tag0}, 128'd4);
        run_vec("h_allones", {160{1'b1}}, 128'd0, 0);
        check("h_allones:const", {tag3, tag2, tag1, tag0}, {32'd0, 32'd0, 32'd1, 32'h3FFFFFFF});
        run_vec("h_pm1_wrap", p160 - 160'd1, 128'd6, 0);
        check("h_pm1_wrap:const", {tag3, tag2, tag1, tag0}, 128'd0);

        // Start while busy is ignored.
        run_vec("busy_start", rand160(), rand128(), 5);

        // Random full-range vectors, some with idle gaps.
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_vec("rand", rand160(), rand128(), (k % 3 == 0) ? 12 : 0);
        end

        // Random vectors clustered around p and 2p.
        for (int k = 0; k < 6; k++) begin
            logic [159:0] hv;
            hv = ((k % 2 == 0) ? p160 : (p160 << 1)) + 160'($urandom_range(0, 20)) - 160'd10;
            run_vec("near_p", hv, rand128(), 0);
        end

        // Mid-run reset: start, re-pulse at cycle 5, reset (with start) at cycle 10.
        @(posedge clk); #1;
        apply(rand160(), rand128());
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        check("midreset:ready", {127'd0, ready}, 128'd1);
        check("midreset:tags", {tag3, tag2, tag1, tag0}, 128'd0);
        prev_tag = 128'd0;
        run_vec("after_reset", 160'd1, 128'd0, 0);
        check("after_reset:const", {tag3, tag2, tag1, tag0}, 128'd1);

        // Tag must stay put while idle.
        repeat (4) @(posedge clk);
        #1;
        check("idle_hold", {tag3, tag2, tag1, tag0}, 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
